pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the eCPU 5-stage pipeline. It combines the hazard unit's load-use stall with execute-stage redirects, instruction-fetch latency and multi-cycle data-memory accesses. From these it produces one stall (hold) and flush (bubble) control per pipeline register. It tracks one outstanding fetch response that must be discarded after a redirect. It also bounds data-memory waits with a timeout and keeps a saturating stall-cycle performance counter.

## Interface
- `STALL_CNT_WIDTH`, default 32: width of the stall-cycle counter.
- `MEM_TIMEOUT`, default 255: maximum frozen cycles for one data access. Must be at least 2. The wait counter is `$clog2(MEM_TIMEOUT+1)` bits.

- `clk_i`  in  1  clock. All state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `load_use_i`  in  1  load-use stall from the hazard unit.
- `redirect_e_i`  in  1  a taken branch or jump in execute; the PC loads the target.
- `imem_valid_i`  in  1  fetch response valid. Held by the fetch unit until consumed.
- `dmem_req_m_i`  in  1  the memory stage is issuing or holding a data access.
- `dmem_ready_i`  in  1  the data access completes this cycle.
- `stall_f_o`, `stall_d_o`, `stall_e_o`, `stall_m_o`  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `flush_d_o`, `flush_e_o`  out  1 each  load a bubble into IF/ID or ID/EX.
- `bubble_w_o`  out  1  load a bubble into MEM/WB.
- `mem_timeout_o`  out  1  sticky: a data access was abandoned.
- `stall_cycles_o`  out  `STALL_CNT_WIDTH`  saturating count of cycles with `stall_f_o`=1.
- `state_o`  out  2  bit0 = FSM is in DMEM_WAIT; bit1 = `discard_q`.

## Operation
**State**
- FSM has two states: RUN and DMEM_WAIT.
- `discard_q` is a 1-bit flag: a stale fetch response is outstanding.
- `wait_cnt` counts frozen cycles for the current data access.

**Frozen cycle.** A cycle is frozen when either:
- the FSM is in RUN, `dmem_req_m_i`=1 and `dmem_ready_i`=0; or
- the FSM is in DMEM_WAIT, `dmem_ready_i`=0 and `wait_cnt`≠`MEM_TIMEOUT`.

A frozen cycle drives:
- `stall_f_o`, `stall_d_o`, `stall_e_o`, `stall_m_o` = 1.
- `flush_d_o`, `flush_e_o` = 0.
- `bubble_w_o` = 1.
- `load_use_i` and `redirect_e_i` are ignored.

**Unfrozen cycle.** Rules are applied in priority order; any output not named is 0.
1. `redirect_e_i`=1: `flush_d_o`=1, `flush_e_o`=1. All stalls are 0.
2. Else `load_use_i`=1: `stall_f_o`=1, `stall_d_o`=1, `flush_e_o`=1.
3. Else `discard_q`=1 or `imem_valid_i`=0: `stall_f_o`=1, `flush_d_o`=1.
4. Else: no stall, no flush.

**FSM transitions**
- RUN → DMEM_WAIT when the cycle is frozen; load `wait_cnt` with 1.
- DMEM_WAIT with `dmem_ready_i`=1 → RUN. That cycle is unfrozen and the access completes normally.
- DMEM_WAIT with `dmem_ready_i`=0 and `wait_cnt`=`MEM_TIMEOUT` → RUN. On this cycle:
  - `mem_timeout_o` is set;
  - the unfrozen rules apply, except `bubble_w_o` is forced to 1 (the abandoned access is not written back).
- DMEM_WAIT otherwise: `wait_cnt` increments.
- At most `MEM_TIMEOUT` consecutive frozen cycles occur per access.

**Discard flag**
- Unfrozen cycle: next `discard_q` = (`redirect_e_i` | `discard_q`) & !`imem_valid_i`.
- Frozen cycle: next `discard_q` = `discard_q` & !`imem_valid_i`.
- A fetch response is consumed in a cycle where `imem_valid_i`=1 and either `stall_f_o`=0 or `discard_q`=1.
- A response consumed while `discard_q`=1 is dropped.

**Counters**
- `stall_cycles_o` increments each cycle with `stall_f_o`=1 and saturates at all-ones.
- `mem_timeout_o` is cleared only by reset.

## Timing
- Reset (asynchronous, active-high):
  - FSM = RUN, `discard_q`=0, `wait_cnt`=0.
  - `stall_cycles_o`=0, `mem_timeout_o`=0, `state_o`=0.
- While `rst_i`=1: all `stall_*_o`=0; `flush_d_o`, `flush_e_o` and `bubble_w_o`=1.
- Reset asserted mid-wait or mid-discard drops the pending state immediately.
- Stall and flush outputs are combinational from the registered state and the current inputs: zero-cycle latency.
- `state_o`, `mem_timeout_o` and `stall_cycles_o` are registered and update one cycle after the causing event.
- `mem_timeout_o` is first seen high the cycle after the release cycle.
- `dmem_ready_i` in the same cycle as `dmem_req_m_i` (RUN): no freeze and no state change.
- A redirect during a freeze is ignored that cycle. The execute stage is held, so the redirect is re-presented once the freeze releases.

## Test plan
- `load_use_i`=1 for 1 cycle, `imem_valid_i`=1 → that cycle `stall_f_o`=1, `stall_d_o`=1, `flush_e_o`=1; next cycle all 0; `stall_cycles_o`=1.
- `redirect_e_i`=1 and `load_use_i`=1 together, `imem_valid_i`=1 → `flush_d_o`=1, `flush_e_o`=1, all stalls 0, `discard_q` stays 0.
- `redirect_e_i`=1 with `imem_valid_i`=0, then response arrives 3 cycles later → `state_o[1]`=1 for 3 cycles with `stall_f_o`=1 and `flush_d_o`=1. Flag clears after the response cycle; the response is dropped.
- `dmem_req_m_i`=1, `dmem_ready_i` arrives 4 cycles after the request → 4 frozen cycles (all stalls 1, `bubble_w_o`=1), release on the ready cycle, FSM back to RUN.
- `MEM_TIMEOUT`=4, `dmem_ready_i` held 0 → exactly 4 frozen cycles, then a release cycle with `bubble_w_o`=1. `mem_timeout_o`=1 from the next cycle and remains 1 until reset.
- `STALL_CNT_WIDTH`=3 with 10 consecutive stall cycles → `stall_cycles_o` saturates at 7. Asserting `rst_i` mid-DMEM_WAIT → `state_o`=0 and the counter is 0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the eCPU 5-stage pipeline: merges load-use, redirect,
// fetch-latency and data-memory waits into per-register hold/bubble controls.
module pipeline_ctrl #(
    parameter int STALL_CNT_WIDTH = 32,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       load_use_i,
    input  logic                       redirect_e_i,
    input  logic                       imem_valid_i,
    input  logic                       dmem_req_m_i,
    input  logic                       dmem_ready_i,
    output logic                       stall_f_o,
    output logic                       stall_d_o,
    output logic                       stall_e_o,
    output logic                       stall_m_o,
    output logic                       flush_d_o,
    output logic                       flush_e_o,
    output logic                       bubble_w_o,
    output logic                       mem_timeout_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o,
    output logic [1:0]                 state_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } state_t;

    state_t                     state_q;
    logic [WAIT_W-1:0]          wait_cnt_q;
    logic                       discard_q;
    logic                       in_wait;
    logic                       at_limit;
    logic                       frozen;
    logic                       timeout_rel;

    always_comb begin
        in_wait     = (state_q == DMEM_WAIT);
        at_limit    = (wait_cnt_q == WAIT_MAX);
        frozen      = in_wait ? (!dmem_ready_i && !at_limit)
                              : (dmem_req_m_i && !dmem_ready_i);
        timeout_rel = in_wait && !dmem_ready_i && at_limit;
    end

    // An abandoned access still gets its MEM/WB bubble so nothing is written back.
    always_comb begin
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        stall_e_o  = 1'b0;
        stall_m_o  = 1'b0;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        bubble_w_o = 1'b0;
        if (rst_i) begin
            flush_d_o  = 1'b1;
            flush_e_o  = 1'b1;
            bubble_w_o = 1'b1;
        end else if (frozen) begin
            stall_f_o  = 1'b1;
            stall_d_o  = 1'b1;
            stall_e_o  = 1'b1;
            stall_m_o  = 1'b1;
            bubble_w_o = 1'b1;
        end else begin
            if (redirect_e_i) begin
                flush_d_o = 1'b1;
                flush_e_o = 1'b1;
            end else if (load_use_i) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                flush_e_o = 1'b1;
            end else if (discard_q || !imem_valid_i) begin
                stall_f_o = 1'b1;
                flush_d_o = 1'b1;
            end
            bubble_w_o = timeout_rel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            discard_q      <= 1'b0;
            mem_timeout_o  <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (frozen) begin
                        state_q    <= DMEM_WAIT;
                        wait_cnt_q <= WAIT_W'(1);
                    end
                end
                DMEM_WAIT: begin
                    if (dmem_ready_i || at_limit) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase

            if (timeout_rel)
                mem_timeout_o <= 1'b1;

            // A redirect seen during a freeze is re-presented later, so only unfrozen cycles arm the flag.
            if (frozen)
                discard_q <= discard_q && !imem_valid_i;
            else
                discard_q <= (redirect_e_i || discard_q) && !imem_valid_i;

            if (stall_f_o && (stall_cycles_o != '1))
                stall_cycles_o <= stall_cycles_o + STALL_CNT_WIDTH'(1);
        end
    end

    assign state_o = {discard_q, (state_q == DMEM_WAIT)};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed literal sequences followed by random stimulus,
// all checked every cycle against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 3;
    localparam int TMO     = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, load_use, redirect, imem_valid, dmem_req, dmem_ready;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0] state;

    int n_compared = 0;
    int n_failed   = 0;
    bit model_on   = 0;

    // Model state: waiting on memory, how many frozen cycles so far, stale fetch pending.
    bit m_wait, m_discard, m_timeout;
    int m_waited, m_cnt;
    bit n_wait, n_discard, n_timeout;
    int n_waited, n_cnt;

    pipeline_ctrl #(.STALL_CNT_WIDTH(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .load_use_i(load_use), .redirect_e_i(redirect),
        .imem_valid_i(imem_valid), .dmem_req_m_i(dmem_req), .dmem_ready_i(dmem_ready),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
        .flush_d_o(flush_d), .flush_e_o(flush_e), .bubble_w_o(bubble_w),
        .mem_timeout_o(mem_timeout), .stall_cycles_o(stall_cycles), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit lu, input bit rd, input bit iv,
                                 input bit rq, input bit ry);
        @(posedge clk);
        #1;
        rst = r; load_use = lu; redirect = rd; imem_valid = iv; dmem_req = rq; dmem_ready = ry;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] vec, input logic [1:0] st,
                               input bit to, input int cnt);
        @(negedge clk);
        compare({name, "_ctrl"}, 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}), 32'(vec));
        compare({name, "_state"}, 32'(state), 32'(st));
        compare({name, "_timeout"}, 32'(mem_timeout), 32'(to));
        compare({name, "_cnt"}, 32'(stall_cycles), 32'(cnt));
    endtask

    // Every-cycle comparison against the model; also computes the model's next state.
    always @(negedge clk) begin
        bit c_wait, c_discard, c_timeout, frz, rel;
        int c_waited, c_cnt;
        logic [6:0] exp;
        if (model_on) begin
            c_wait    = rst ? 1'b0 : m_wait;
            c_waited  = rst ? 0    : m_waited;
            c_discard = rst ? 1'b0 : m_discard;
            c_timeout = rst ? 1'b0 : m_timeout;
            c_cnt     = rst ? 0    : m_cnt;
            frz = c_wait ? (!dmem_ready && c_waited < TMO) : (dmem_req && !dmem_ready);
            rel = c_wait && !dmem_ready && c_waited >= TMO;
            if (rst)             exp = 7'b0000111;
            else if (frz)        exp = 7'b1111001;
            else if (redirect)   exp = 7'b0000110;
            else if (load_use)   exp = 7'b1100010;
            else if (c_discard || !imem_valid) exp = 7'b1000100;
            else                 exp = 7'b0000000;
            if (!rst && !frz && rel) exp[0] = 1'b1;

            compare("model_ctrl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}), 32'(exp));
            compare("model_state", 32'(state), 32'({c_discard, c_wait}));
            compare("model_timeout", 32'(mem_timeout), 32'(c_timeout));
            compare("model_cnt", 32'(stall_cycles), 32'(c_cnt));

            if (rst) begin
                n_wait = 0; n_waited = 0; n_discard = 0; n_timeout = 0; n_cnt = 0;
            end else begin
                n_wait = c_wait; n_waited = c_waited;
                if (!c_wait && frz) begin
                    n_wait = 1; n_waited = 1;
                end else if (c_wait && (dmem_ready || c_waited >= TMO)) begin
                    n_wait = 0; n_waited = 0;
                end else if (c_wait) begin
                    n_waited = c_waited + 1;
                end
                n_timeout = c_timeout || rel;
                n_discard = frz ? (c_discard && !imem_valid) : ((redirect || c_discard) && !imem_valid);
                n_cnt = (exp[6] && c_cnt < CNT_MAX) ? c_cnt + 1 : c_cnt;
            end
        end
    end

    always @(posedge clk) begin
        if (model_on) begin
            m_wait <= n_wait; m_waited <= n_waited; m_discard <= n_discard;
            m_timeout <= n_timeout; m_cnt <= n_cnt;
        end
    end

    initial begin
        rst = 1'b1; load_use = 0; redirect = 0; imem_valid = 0; dmem_req = 0; dmem_ready = 0;
        model_on = 1;

        applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("reset", 7'b0000111, 2'b00, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0); checkOutput("load_use", 7'b1100010, 2'b00, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("after_lu", 7'b0000000, 2'b00, 0, 1);
        applyStimulus(0, 1, 1, 1, 0, 0); checkOutput("redir_lu", 7'b0000110, 2'b00, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("no_discard", 7'b0000000, 2'b00, 0, 1);
        // Four frozen cycles then a forced-bubble release with ready never arriving.
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("frz1", 7'b1111001, 2'b00, 0, 1);
        applyStimulus(0, 0, 1, 1, 1, 0); checkOutput("frz2", 7'b1111001, 2'b01, 0, 2);
        applyStimulus(0, 1, 0, 1, 1, 0); checkOutput("frz3", 7'b1111001, 2'b01, 0, 3);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("frz4", 7'b1111001, 2'b01, 0, 4);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("tmo_rel", 7'b0000001, 2'b01, 0, 5);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("tmo_seen", 7'b0000000, 2'b00, 1, 5);
        applyStimulus(0, 0, 1, 0, 0, 0); checkOutput("redir_nv", 7'b0000110, 2'b00, 1, 5);
        applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("disc1", 7'b1000100, 2'b10, 1, 5);
        applyStimulus(0, 0, 0, 0, 0, 0); checkOutput("disc2", 7'b1000100, 2'b10, 1, 6);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("disc_drop", 7'b1000100, 2'b10, 1, 7);
        applyStimulus(0, 0, 0, 1, 0, 0); checkOutput("disc_clr", 7'b0000000, 2'b00, 1, 7);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("frz_a", 7'b1111001, 2'b00, 1, 7);
        applyStimulus(0, 0, 0, 1, 1, 0); checkOutput("frz_b", 7'b1111001, 2'b01, 1, 7);
        applyStimulus(1, 0, 0, 1, 1, 0); checkOutput("rst_mid", 7'b0000111, 2'b00, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1); checkOutput("rdy_same", 7'b0000000, 2'b00, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1); checkOutput("rdy_same2", 7'b0000000, 2'b00, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(149) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                          $urandom_range(2) != 0, $urandom_range(1) == 0, $urandom_range(4) == 0);
        end
        @(negedge clk);
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
